// File: rtl/cakegame_play_input_pkg.sv
// Shared definitions for the cake game player-input front end.
// Holds the debounce FSM state codes and the default parameter values.
package cakegame_play_input_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DEBOUNCE     = 2'd1,
    ACCEPT       = 2'd2,
    WAIT_RELEASE = 2'd3
  } state_t;

  localparam int N_BUTTONS_DEFAULT     = 4;
  // 1 ms at 50 MHz in hardware; the short value keeps simulations fast.
  localparam int DEBOUNCE_CYCLES_SYNTH = 50000;
  localparam int DEBOUNCE_CYCLES_SIM   = 4;

endpackage

// File: rtl/cakegame_play_input_sync_2ff.sv
// Two-flop synchronizer for a bus of asynchronous level inputs.
// Bits are synchronized independently; consumers must tolerate skew between bits.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // NOTE: flops use non-blocking assignments so both stages sample the pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/cakegame_play_input.sv
// Player-input front end: synchronizes and debounces the play buttons and
// emits a one-cycle has_play pulse with a held one-hot/binary play code.
module cakegame_play_input
  import cakegame_play_input_pkg::*;
#(
  parameter int N_BUTTONS       = N_BUTTONS_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SYNTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [N_BUTTONS-1:0]         buttons,
  input  logic                         enable,
  output logic                         has_play,
  output logic [N_BUTTONS-1:0]         play,
  output logic [$clog2(N_BUTTONS)-1:0] play_index,
  output logic [1:0]                   state
);

  localparam int IW = $clog2(N_BUTTONS);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  function automatic logic [IW-1:0] encode(input logic [N_BUTTONS-1:0] onehot);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_BUTTONS; i++)
      if (onehot[i]) idx = idx | IW'(i);
    return idx;
  endfunction

  logic [N_BUTTONS-1:0] w_sync;
  logic                 w_single;
  state_t               w_state_nxt;
  logic [CW-1:0]        w_cnt_nxt;
  logic [N_BUTTONS-1:0] w_cand_nxt;
  logic                 w_accept;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [N_BUTTONS-1:0] r_cand;
  logic                 r_has_play;
  logic [N_BUTTONS-1:0] r_play;
  logic [IW-1:0]        r_play_index;

  sync_2ff #(.WIDTH(N_BUTTONS)) u_sync (
    .clock (clock),
    .reset (reset),
    .i_d   (buttons),
    .o_q   (w_sync)
  );

  assign w_single = (w_sync != '0) && ((w_sync & (w_sync - N_BUTTONS'(1))) == '0);

  // Reset lands in WAIT_RELEASE so a button held through reset is never reported.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= WAIT_RELEASE;
      r_cnt   <= '0;
      r_cand  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cand  <= w_cand_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    case (r_state)
      IDLE: begin
        if (w_single) begin
          w_cand_nxt  = w_sync;
          w_cnt_nxt   = '0;
          w_state_nxt = DEBOUNCE;
        end else if (w_sync != '0) begin
          w_cnt_nxt   = '0;
          w_state_nxt = WAIT_RELEASE;
        end
      end
      DEBOUNCE: begin
        if (w_sync == r_cand) begin
          if (r_cnt == CNT_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ACCEPT;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end else if (w_sync == '0) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt   = '0;
          w_state_nxt = WAIT_RELEASE;
        end
      end
      ACCEPT: begin
        w_cnt_nxt   = '0;
        w_state_nxt = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (w_sync != '0) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = WAIT_RELEASE;
      end
    endcase
  end

  // A disabled accept consumes the press without touching the play code.
  assign w_accept = (w_state_nxt == ACCEPT) && (r_state != ACCEPT) && enable;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_has_play   <= 1'b0;
      r_play       <= '0;
      r_play_index <= '0;
    end else begin
      r_has_play <= w_accept;
      if (w_accept) begin
        r_play       <= r_cand;
        r_play_index <= encode(r_cand);
      end
    end
  end

  assign has_play   = r_has_play;
  assign play       = r_play;
  assign play_index = r_play_index;
  assign state      = r_state;

endmodule

// File: tb/tb_cakegame_play_input.sv
// Self-checking bench for cakegame_play_input: directed sequences, a segment
// table and randomized stimulus compared each cycle against a behavioural model.
module tb_cakegame_play_input;
  import cakegame_play_input_pkg::*;

  localparam int NB = 4;
  localparam int DC = DEBOUNCE_CYCLES_SIM;

  logic          clock;
  logic          reset;
  logic [NB-1:0] buttons;
  logic          enable;
  logic          has_play;
  logic [NB-1:0] play;
  logic [1:0]    play_index;
  logic [1:0]    state;

  cakegame_play_input #(.N_BUTTONS(NB), .DEBOUNCE_CYCLES(DC)) dut (
    .clock      (clock),
    .reset      (reset),
    .buttons    (buttons),
    .enable     (enable),
    .has_play   (has_play),
    .play       (play),
    .play_index (play_index),
    .state      (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: "armed" after a full run of released samples, a
  // candidate press is reported once it has been seen DC more times in a row.
  logic [NB-1:0] m_pipe[$];
  bit            m_armed;
  int            m_zeros;
  logic [NB-1:0] m_cand;
  int            m_hold;
  bit            m_in_accept;
  logic          m_has_play;
  logic [NB-1:0] m_play;
  logic [1:0]    m_idx;

  function automatic logic [1:0] idx_of(input logic [NB-1:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < NB; i++)
      if (v[i]) r = 2'(i);
    return r;
  endfunction

  function automatic logic [1:0] m_state();
    if (m_in_accept)   return 2'd2;
    if (!m_armed)      return 2'd3;
    if (m_cand != '0)  return 2'd1;
    return 2'd0;
  endfunction

  task automatic model_edge();
    logic [NB-1:0] s;
    if (reset) begin
      m_pipe = '{4'b0000, 4'b0000};
      m_armed = 0; m_zeros = 0; m_cand = '0; m_hold = 0; m_in_accept = 0;
      m_has_play = 1'b0; m_play = '0; m_idx = '0;
      return;
    end
    s = m_pipe.pop_front();
    m_pipe.push_back(buttons);
    m_has_play = 1'b0;
    if (m_in_accept) begin
      m_in_accept = 0; m_armed = 0; m_zeros = 0;
    end else if (!m_armed) begin
      if (s == '0) begin
        m_zeros++;
        if (m_zeros == DC) m_armed = 1;
      end else m_zeros = 0;
    end else if (m_cand == '0) begin
      if ($countones(s) == 1) begin
        m_cand = s; m_hold = 0;
      end else if (s != '0) begin
        m_armed = 0; m_zeros = 0;
      end
    end else if (s == m_cand) begin
      m_hold++;
      if (m_hold == DC) begin
        m_in_accept = 1;
        if (enable) begin
          m_has_play = 1'b1; m_play = m_cand; m_idx = idx_of(m_cand);
        end
        m_cand = '0;
      end
    end else if (s == '0) begin
      m_cand = '0;
    end else begin
      m_cand = '0; m_armed = 0; m_zeros = 0;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    if (has_play) n_pulses++;
    check("m_has_play", 32'(has_play), 32'(m_has_play));
    check("m_play", 32'(play), 32'(m_play));
    check("m_play_index", 32'(play_index), 32'(m_idx));
    check("m_state", 32'(state), 32'(m_state()));
  endtask

  typedef struct {
    logic [NB-1:0] btn;
    logic          en;
    int            n;
    int            pulses;
    logic [NB-1:0] play;
    logic [1:0]    st;
  } seg_t;

  seg_t segs[14];

  initial begin
    segs[0]  = '{4'b0011, 1'b1, 10, 0, 4'b0010, 2'd3};
    segs[1]  = '{4'b0000, 1'b1,  8, 0, 4'b0010, 2'd0};
    segs[2]  = '{4'b1000, 1'b1, 10, 1, 4'b1000, 2'd3};
    segs[3]  = '{4'b0000, 1'b1,  8, 0, 4'b1000, 2'd0};
    segs[4]  = '{4'b0001, 1'b0, 10, 0, 4'b1000, 2'd3};
    segs[5]  = '{4'b0000, 1'b1,  8, 0, 4'b1000, 2'd0};
    segs[6]  = '{4'b0001, 1'b1, 10, 1, 4'b0001, 2'd3};
    segs[7]  = '{4'b0000, 1'b1,  8, 0, 4'b0001, 2'd0};
    segs[8]  = '{4'b0100, 1'b1, 10, 1, 4'b0100, 2'd3};
    segs[9]  = '{4'b0000, 1'b1,  2, 0, 4'b0100, 2'd3};
    segs[10] = '{4'b0100, 1'b1,  2, 0, 4'b0100, 2'd3};
    segs[11] = '{4'b0000, 1'b1,  6, 0, 4'b0100, 2'd0};
    segs[12] = '{4'b0001, 1'b1, 10, 1, 4'b0001, 2'd3};
    segs[13] = '{4'b0000, 1'b1,  8, 0, 4'b0001, 2'd0};

    reset = 1'b1; buttons = '0; enable = 1'b1;
    repeat (2) tick();
    check("rst_has_play", 32'(has_play), 32'd0);
    check("rst_play", 32'(play), 32'd0);
    check("rst_state", 32'(state), 32'd3);
    reset = 1'b0;

    // Clean press: pulse only after edge 6, code held afterwards.
    repeat (8) tick();
    check("s1_idle", 32'(state), 32'd0);
    buttons = 4'b0100; n_pulses = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      check("s1_pulse_edge", 32'(has_play), 32'(k == 6));
    end
    check("s1_pulses", 32'(n_pulses), 32'd1);
    check("s1_play", 32'(play), 32'h4);
    check("s1_index", 32'(play_index), 32'd2);
    buttons = '0; repeat (8) tick();

    // Bounce: pulse 6 edges after the final rising edge.
    n_pulses = 0;
    buttons = 4'b0010; repeat (2) tick();
    buttons = 4'b0000; tick();
    buttons = 4'b0010;
    for (int k = 0; k < 16; k++) begin
      tick();
      check("s2_pulse_edge", 32'(has_play), 32'(k == 6));
    end
    check("s2_pulses", 32'(n_pulses), 32'd1);
    check("s2_play", 32'(play), 32'h2);
    buttons = '0; repeat (8) tick();

    // Multi-press, disabled press and release-debounce segments.
    for (int i = 0; i < 14; i++) begin
      buttons = segs[i].btn; enable = segs[i].en; n_pulses = 0;
      repeat (segs[i].n) tick();
      check($sformatf("seg%0d_pulses", i), 32'(n_pulses), 32'(segs[i].pulses));
      check($sformatf("seg%0d_play", i), 32'(play), 32'(segs[i].play));
      check($sformatf("seg%0d_state", i), 32'(state), 32'(segs[i].st));
    end

    // Reset while held mid-debounce.
    buttons = 4'b0100; repeat (3) tick();
    reset = 1'b1; tick();
    check("s5_rst_play", 32'(play), 32'd0);
    check("s5_rst_state", 32'(state), 32'd3);
    reset = 1'b0; n_pulses = 0;
    repeat (20) tick();
    check("s5_held_pulses", 32'(n_pulses), 32'd0);
    check("s5_held_state", 32'(state), 32'd3);
    buttons = '0; repeat (6) tick();
    check("s5_rel_state", 32'(state), 32'd0);
    buttons = 4'b0100; n_pulses = 0;
    repeat (10) tick();
    check("s5_pulses", 32'(n_pulses), 32'd1);
    check("s5_play", 32'(play), 32'h4);
    buttons = '0; repeat (8) tick();

    // Randomized bursts checked by the model every cycle.
    for (int b = 0; b < 120; b++) begin
      case ($urandom_range(0, 3))
        0:       buttons = '0;
        1, 2:    buttons = NB'(1 << $urandom_range(0, NB - 1));
        default: buttons = NB'($urandom);
      endcase
      enable = ($urandom_range(0, 3) != 0);
      reset  = ($urandom_range(0, 29) == 0);
      tick();
      reset = 1'b0;
      repeat ($urandom_range(1, 10)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
